// File: rtl/bram_loader_pkg.sv
// Shared types and constants for the BRAM write-side loader.
package bram_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam int BRAM_WORD_W    = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int LANE_W         = $clog2(BYTES_PER_WORD);
  localparam int DEFAULT_ADDR_W = 16;
endpackage

// File: rtl/bram_loader_byte_packer.sv
// Packs bytes little-endian into a 64-bit word; word_full strobes when the top lane is pushed.
module byte_packer
  import bram_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [7:0]             data,
  output logic [BRAM_WORD_W-1:0] word,
  output logic                   word_full
);
  logic [LANE_W-1:0]      idx_reg;
  logic [BRAM_WORD_W-1:0] pack_reg;

  // word = pack register with the incoming byte in lane idx; lane 0 starts a fresh word
  // with every other lane zero, so a partial word always has clean upper lanes.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      assign word[8*gi +: 8] = (idx_reg == LANE_W'(gi)) ? data :
                               ((idx_reg == '0) ? 8'h00 : pack_reg[8*gi +: 8]);
    end
  endgenerate

  assign word_full = push && (idx_reg == LANE_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg  <= '0;
      pack_reg <= '0;
    end else if (clear) begin
      idx_reg  <= '0;
      pack_reg <= '0;
    end else if (push) begin
      idx_reg  <= idx_reg + LANE_W'(1);
      pack_reg <= word;
    end
  end
endmodule

// File: rtl/bram_loader.sv
// Byte-stream to 64-bit BRAM word loader. Define BRAM_LOADER_ZERO_PAD_EN to write a
// zero-padded trailing partial word instead of discarding it.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int CNT_W  = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       num_bytes,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [7:0]             s_data,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [BRAM_WORD_W-1:0] wr_data,
  output logic                   busy,
  output logic                   done
);
  state_t                 state_reg;
  logic [ADDR_W-1:0]      addr_reg;
  logic [CNT_W-1:0]       remaining_reg;
  logic [BRAM_WORD_W-1:0] word;
  logic                   word_full;
  logic                   accept;
  logic                   start_ok;

  assign accept   = s_valid && s_ready && (state_reg == LOAD);
  assign start_ok = start && (state_reg == IDLE);

  byte_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .push      (accept),
    .data      (s_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      s_ready       <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            addr_reg      <= base_addr;
            remaining_reg <= num_bytes;
            busy          <= 1'b1;
            if (num_bytes == '0) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              state_reg <= LOAD;
              s_ready   <= 1'b1;
            end
          end
        end
        LOAD: begin
          // remaining==0 here means the final full word is being written this cycle
          if (remaining_reg == '0) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else if (accept) begin
            remaining_reg <= remaining_reg - CNT_W'(1);
            if (word_full) begin
              wr_en    <= 1'b1;
              wr_data  <= word;
              wr_addr  <= addr_reg;
              addr_reg <= addr_reg + ADDR_W'(1);
            end
            if (remaining_reg == CNT_W'(1)) begin
              s_ready <= 1'b0;
              if (!word_full) begin
                state_reg <= FLUSH;
`ifdef BRAM_LOADER_ZERO_PAD_EN
                wr_en    <= 1'b1;
                wr_data  <= word;
                wr_addr  <= addr_reg;
                addr_reg <= addr_reg + ADDR_W'(1);
`endif
              end
            end
          end
        end
        FLUSH: begin
          state_reg <= DONE;
          done      <= 1'b1;
        end
        DONE: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_loader.sv
// Directed self-checking bench for bram_loader.
module tb_bram_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [19:0] num_bytes = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  logic [15:0] q_addr[$];
  logic [63:0] q_data[$];
  int          q_cyc[$];
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          we_long = 0;
  logic        prev_we = 1'b0;
  int          acc_cyc = 0;

  bram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
      q_cyc.push_back(cyc);
      if (prev_we) we_long++;
      $display("  write addr=%h data=%h cyc=%0d", wr_addr, wr_data, cyc);
    end
    prev_we = wr_en;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_cyc.delete();
    done_cnt = 0;
    we_long = 0;
  endtask

  task automatic start_xfer(input logic [15:0] b, input logic [19:0] n);
    base_addr = b;
    num_bytes = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Sends n bytes first, first+1, ...; gap inserts an idle s_valid cycle between bytes.
  task automatic send(input logic [7:0] first, input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int  guard;
      logic ok;
      s_valid = 1'b1;
      s_data  = first + 8'(i);
      guard   = 0;
      do begin
        ok = s_ready;
        tick();
        guard++;
      end while (!ok && guard < 50);
      if (!ok) begin
        errors++;
        $display("FAIL send_timeout byte=%0d s_ready=%b required=1", i, s_ready);
      end
      acc_cyc = cyc;
      if (gap) begin
        s_valid = 1'b0;
        tick();
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (done_cnt == 0 && guard < 60) begin
      tick();
      guard++;
    end
    checks++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL done_timeout done_cnt=%0d required>=1", done_cnt);
    end
    repeat (3) tick();
  endtask

  task automatic check_two_words(input string name, input logic [15:0] a0, input logic [15:0] a1);
    checks++;
    if (q_addr.size() !== 2) begin
      errors++;
      $display("FAIL %s_count writes=%0d required=2", name, q_addr.size());
    end else begin
      checks += 4;
      if (q_addr[0] !== a0) begin errors++; $display("FAIL %s_addr0 got=%h required=%h", name, q_addr[0], a0); end
      if (q_data[0] !== 64'h0706050403020100) begin errors++; $display("FAIL %s_data0 got=%h required=0706050403020100", name, q_data[0]); end
      if (q_addr[1] !== a1) begin errors++; $display("FAIL %s_addr1 got=%h required=%h", name, q_addr[1], a1); end
      if (q_data[1] !== 64'h0F0E0D0C0B0A0908) begin errors++; $display("FAIL %s_data1 got=%h required=0F0E0D0C0B0A0908", name, q_data[1]); end
      checks++;
      if (done_cyc !== q_cyc[1] + 1) begin errors++; $display("FAIL %s_done_timing done_cyc=%0d required=%0d", name, done_cyc, q_cyc[1] + 1); end
    end
    checks += 2;
    if (done_cnt !== 1) begin errors++; $display("FAIL %s_done_count got=%0d required=1", name, done_cnt); end
    if (we_long !== 0) begin errors++; $display("FAIL %s_we_width long_pulses=%0d required=0", name, we_long); end
  endtask

  task automatic test_reset();
    checks += 6;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got=%b required=0", s_ready); end
    if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got=%b required=0", wr_en); end
    if (wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr got=%h required=0000", wr_addr); end
    if (wr_data !== 64'h0) begin errors++; $display("FAIL reset_wr_data got=%h required=0", wr_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b required=0", done); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int eighth_cyc;
    clear_log();
    start_xfer(16'h0010, 20'd16);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_after_start s_ready=%b busy=%b required=1 1", s_ready, busy);
    end
    send(8'h00, 8, 1'b0);
    eighth_cyc = acc_cyc;
    send(8'h08, 8, 1'b0);
    wait_done();
    check_two_words("basic", 16'h0010, 16'h0011);
    if (q_cyc.size() > 0) begin
      checks++;
      if (q_cyc[0] !== eighth_cyc) begin errors++; $display("FAIL basic_latency wr_cyc=%0d required=%0d", q_cyc[0], eighth_cyc); end
    end
    $display("test_basic done");
  endtask

  task automatic test_stall();
    clear_log();
    start_xfer(16'h0010, 20'd16);
    send(8'h00, 16, 1'b1);
    wait_done();
    check_two_words("stall", 16'h0010, 16'h0011);
    $display("test_stall done");
  endtask

  task automatic test_partial();
    clear_log();
    start_xfer(16'h0000, 20'd10);
    send(8'h00, 10, 1'b0);
    wait_done();
    checks += 3;
    if (q_addr.size() > 0 && (q_addr[0] !== 16'h0000 || q_data[0] !== 64'h0706050403020100)) begin
      errors++;
      $display("FAIL partial_word0 addr=%h data=%h required=0000 0706050403020100", q_addr[0], q_data[0]);
    end
    if (done_cnt !== 1) begin errors++; $display("FAIL partial_done_count got=%0d required=1", done_cnt); end
`ifdef BRAM_LOADER_ZERO_PAD_EN
    if (q_addr.size() !== 2) begin
      errors++;
      $display("FAIL partial_count writes=%0d required=2", q_addr.size());
    end else begin
      checks += 2;
      if (q_addr[1] !== 16'h0001 || q_data[1] !== 64'h0000000000000908) begin
        errors++;
        $display("FAIL partial_pad addr=%h data=%h required=0001 0000000000000908", q_addr[1], q_data[1]);
      end
      if (done_cyc !== q_cyc[1] + 1) begin errors++; $display("FAIL partial_done_timing got=%0d required=%0d", done_cyc, q_cyc[1] + 1); end
    end
`else
    if (q_addr.size() !== 1) begin errors++; $display("FAIL partial_count writes=%0d required=1", q_addr.size()); end
`endif
    $display("test_partial done");
  endtask

  task automatic test_wrap();
    clear_log();
    start_xfer(16'hFFFF, 20'd16);
    send(8'h00, 16, 1'b0);
    wait_done();
    check_two_words("wrap", 16'hFFFF, 16'h0000);
    $display("test_wrap done");
  endtask

  task automatic test_zero_and_busy_start();
    clear_log();
    start_xfer(16'h1234, 20'd0);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b required=1", done); end
    if (s_ready !== 1'b0) begin errors++; $display("FAIL zero_s_ready got=%b required=0", s_ready); end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got=%b required=0", done); end
    repeat (3) tick();
    checks += 2;
    if (q_addr.size() !== 0) begin errors++; $display("FAIL zero_writes got=%0d required=0", q_addr.size()); end
    if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_count got=%0d required=1", done_cnt); end

    clear_log();
    start_xfer(16'h0020, 20'd8);
    send(8'h30, 3, 1'b0);
    start_xfer(16'h0099, 20'd2);
    send(8'h33, 5, 1'b0);
    wait_done();
    checks++;
    if (q_addr.size() !== 1) begin
      errors++;
      $display("FAIL busy_start_count writes=%0d required=1", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 16'h0020 || q_data[0] !== 64'h3736353433323130) begin
        errors++;
        $display("FAIL busy_start_word addr=%h data=%h required=0020 3736353433323130", q_addr[0], q_data[0]);
      end
    end
    $display("test_zero_and_busy_start done");
  endtask

  task automatic test_reset_mid();
    clear_log();
    start_xfer(16'h0040, 20'd8);
    send(8'h50, 5, 1'b0);
    rst_n = 1'b0;
    #2;
    checks += 4;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready got=%b required=0", s_ready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b required=0", busy); end
    if (wr_addr !== 16'h0 || wr_data !== 64'h0) begin errors++; $display("FAIL midrst_wr got=%h %h required=0000 0", wr_addr, wr_data); end
    if (wr_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_pulses wr_en=%b done=%b required=0 0", wr_en, done); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks += 2;
    if (q_addr.size() !== 0) begin errors++; $display("FAIL midrst_writes got=%0d required=0", q_addr.size()); end
    if (done_cnt !== 0) begin errors++; $display("FAIL midrst_done got=%0d required=0", done_cnt); end

    clear_log();
    start_xfer(16'h0040, 20'd8);
    send(8'hA0, 8, 1'b0);
    wait_done();
    checks++;
    if (q_addr.size() !== 1) begin
      errors++;
      $display("FAIL postrst_count writes=%0d required=1", q_addr.size());
    end else begin
      checks++;
      if (q_addr[0] !== 16'h0040 || q_data[0] !== 64'hA7A6A5A4A3A2A1A0) begin
        errors++;
        $display("FAIL postrst_word addr=%h data=%h required=0040 A7A6A5A4A3A2A1A0", q_addr[0], q_data[0]);
      end
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    test_basic();
    test_stall();
    test_partial();
    test_wrap();
    test_zero_and_busy_start();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
